led_blink_arbiter: RTL

Shares the board's single blink LED output between up to NUM_REQ requesters, each asking for a blink at its own half-period in milliseconds. It contains a millisecond prescaler, a half-period counter, and a round-robin grant state machine with a fixed dwell per grant. It sits between status sources (heartbeat, error, activity) and the LED pin, replacing ad-hoc free-running blink counters.

---
 rtl/led_blink_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/led_blink_arbiter.sv
// Round-robin owner of the single blink LED: each granted requester blinks at its
// own half-period (ms) for a fixed number of toggles before the grant is re-arbitrated.
module led_blink_arbiter #(
  parameter int unsigned CLOCK_FREQUENCY = 27000000,
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DWELL_TOGGLES   = 4
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic [NUM_REQ-1:0]      Req,
  input  logic [16*NUM_REQ-1:0]   Half_period_ms,
  output logic [NUM_REQ-1:0]      Grant,
  output logic                    Busy,
  output logic                    IO_voltage
);

  localparam int unsigned CPM = CLOCK_FREQUENCY / 1000;
  localparam int unsigned PW  = (CPM > 1) ? $clog2(CPM) : 1;
  localparam int unsigned TW  = $clog2(DWELL_TOGGLES + 1);
  localparam int unsigned RW  = $clog2(NUM_REQ);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state_q, state_n;
  logic [RW-1:0]      ptr_q, ptr_n;
  logic [15:0]        hp_q, hp_n;
  logic [PW-1:0]      presc_q, presc_n;
  logic [15:0]        ms_q, ms_n;
  logic [TW-1:0]      tog_q, tog_n;
  logic [NUM_REQ-1:0] grant_q, grant_n;
  logic               io_q, io_n;
  logic               busy_q, busy_n;

  logic               win_valid;
  logic [RW-1:0]      win_idx;
  logic [15:0]        win_hp_raw;
  logic [15:0]        win_hp;
  logic [NUM_REQ-1:0] win_onehot;
  logic               tick;
  int unsigned        idx;

  assign Grant      = grant_q;
  assign Busy       = busy_q;
  assign IO_voltage = io_q;

  // Round-robin search starting after the pointer; the pointer itself comes last.
  always_comb begin
    win_valid  = 1'b0;
    win_idx    = '0;
    win_hp_raw = '0;
    idx        = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!win_valid && Req[RW'(idx)]) begin
        win_valid = 1'b1;
        win_idx   = RW'(idx);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (RW'(j) == win_idx) win_hp_raw = Half_period_ms[16*j +: 16];
    end
    win_hp     = (win_hp_raw == 16'd0) ? 16'd1 : win_hp_raw;
    win_onehot = NUM_REQ'(1) << win_idx;
  end

  assign tick = (presc_q == PW'(CPM - 1));

  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    hp_n    = hp_q;
    presc_n = presc_q;
    ms_n    = ms_q;
    tog_n   = tog_q;
    grant_n = grant_q;
    io_n    = io_q;
    case (state_q)
      ST_IDLE: begin
        grant_n = '0;
        io_n    = 1'b0;
        presc_n = '0;
        ms_n    = '0;
        tog_n   = '0;
        if (win_valid) begin
          grant_n = win_onehot;
          ptr_n   = win_idx;
          hp_n    = win_hp;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if ((Req & grant_q) == '0) begin
          // Owner released: drop to IDLE, arbitration waits for the next edge.
          grant_n = '0;
          io_n    = 1'b0;
          presc_n = '0;
          ms_n    = '0;
          tog_n   = '0;
          state_n = ST_IDLE;
        end else begin
          presc_n = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (ms_q == hp_q - 16'd1) begin
              ms_n  = '0;
              io_n  = ~io_q;
              tog_n = tog_q + TW'(1);
              if (tog_q == TW'(DWELL_TOGGLES - 1)) begin
                // Dwell end: LED is back low, hand over without an idle cycle.
                grant_n = win_onehot;
                ptr_n   = win_idx;
                hp_n    = win_hp;
                presc_n = '0;
                tog_n   = '0;
                io_n    = 1'b0;
              end
            end else begin
              ms_n = ms_q + 16'd1;
            end
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
        io_n    = 1'b0;
      end
    endcase
    busy_n = |grant_n;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= RW'(NUM_REQ - 1);
      hp_q    <= 16'd1;
      presc_q <= '0;
      ms_q    <= '0;
      tog_q   <= '0;
      grant_q <= '0;
      io_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      hp_q    <= hp_n;
      presc_q <= presc_n;
      ms_q    <= ms_n;
      tog_q   <= tog_n;
      grant_q <= grant_n;
      io_q    <= io_n;
      busy_q  <= busy_n;
    end
  end

endmodule
